// File: rtl/mux8way_tdm_tx.sv
// Time-division multiplexed transmitter: serialises an 8-bit frame one slot at a time,
// slot index and bit presented for a downstream DMux8Way, each slot held HOLD cycles.
module mux8way_tdm_tx #(
   parameter int unsigned HOLD = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       in_valid_i,
   input  logic [7:0] in_data_i,
   output logic       in_ready_o,
   input  logic       out_en_i,
   output logic       out_bit_o,
   output logic [2:0] out_sel_o,
   output logic       out_valid_o,
   output logic       out_first_o,
   output logic       out_last_o
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   localparam logic [3:0] HOLD_MAX = 4'(HOLD - 1);

   state_e     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic [3:0] hold_q, hold_d;
   logic [7:0] frame_q, frame_d;
   logic       slot_end_s;
   logic       in_ready_s;
   logic       accept_s;

   // A slot only advances on an enabled cycle that completes its hold time.
   always_comb begin
      slot_end_s = (hold_q == HOLD_MAX) && out_en_i;
      if (state_q == IDLE) begin
         in_ready_s = 1'b1;
      end else begin
         in_ready_s = slot_end_s && (sel_q == 3'd7);
      end
      accept_s = in_valid_i && in_ready_s;
   end

   // Next-state logic; a frame accepted at the end of slot 7 restarts at slot 0 with no bubble.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      hold_d  = hold_q;
      frame_d = frame_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               state_d = SEND;
               frame_d = in_data_i;
               sel_d   = 3'd0;
               hold_d  = 4'd0;
            end else begin
               state_d = IDLE;
            end
         end
         SEND: begin
            if (out_en_i) begin
               if (hold_q == HOLD_MAX) begin
                  hold_d = 4'd0;
                  if (sel_q == 3'd7) begin
                     sel_d = 3'd0;
                     if (accept_s) begin
                        frame_d = in_data_i;
                     end else begin
                        state_d = IDLE;
                     end
                  end else begin
                     sel_d = sel_q + 3'd1;
                  end
               end else begin
                  hold_d = hold_q + 4'd1;
               end
            end else begin
               hold_d = hold_q;
            end
         end
         default: begin
            state_d = IDLE;
            sel_d   = 3'd0;
            hold_d  = 4'd0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sel_q   <= 3'd0;
         hold_q  <= 4'd0;
         frame_q <= 8'd0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         hold_q  <= hold_d;
         frame_q <= frame_d;
      end
   end

   // Line outputs are pure decodes of the state registers and are forced quiet in IDLE.
   always_comb begin
      in_ready_o  = in_ready_s;
      out_sel_o   = sel_q;
      out_valid_o = (state_q == SEND);
      if (state_q == SEND) begin
         out_bit_o   = frame_q[sel_q];
         out_first_o = (sel_q == 3'd0);
         out_last_o  = (sel_q == 3'd7);
      end else begin
         out_bit_o   = 1'b0;
         out_first_o = 1'b0;
         out_last_o  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mux8way_tdm_tx.sv
// Bench for mux8way_tdm_tx: HOLD=1 and HOLD=4 instances driven in parallel, checked
// every cycle against a position-count model, plus directed literal scenarios.
module tb_mux8way_tdm_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       out_en;

   logic [1:0] o_ready, o_bit, o_valid, o_first, o_last;
   logic [2:0] o_sel [2];

   int n_pass  = 0;
   int n_total = 0;

   // model: frame held, and count of enabled cycles since the frame's first slot
   int         HOLD_OF [2] = '{1, 4};
   bit         m_busy  [2];
   logic [7:0] m_frame [2];
   int         m_pos   [2];

   // downstream reconstruction for the HOLD=1 instance
   logic [7:0] sent_q [$];
   logic [7:0] cap;
   int         frames_done = 0;

   always #5 clk = ~clk;

   mux8way_tdm_tx #(.HOLD(1)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(o_ready[0]), .out_en_i(out_en), .out_bit_o(o_bit[0]),
      .out_sel_o(o_sel[0]), .out_valid_o(o_valid[0]), .out_first_o(o_first[0]),
      .out_last_o(o_last[0]));

   mux8way_tdm_tx #(.HOLD(4)) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_data_i(in_data),
      .in_ready_o(o_ready[1]), .out_en_i(out_en), .out_bit_o(o_bit[1]),
      .out_sel_o(o_sel[1]), .out_valid_o(o_valid[1]), .out_first_o(o_first[1]),
      .out_last_o(o_last[1]));

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Per-cycle comparison against the model, then advance the model for the coming edge.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int   h;
         bit   e_ready, acc;
         int   e_sel;
         h       = HOLD_OF[d];
         e_ready = !m_busy[d] || ((m_pos[d] == 8*h - 1) && out_en);
         e_sel   = m_busy[d] ? (m_pos[d] / h) : 0;
         chk($sformatf("d%0d_valid", d), int'(o_valid[d]), int'(m_busy[d]));
         chk($sformatf("d%0d_sel", d),   int'(o_sel[d]),   e_sel);
         chk($sformatf("d%0d_bit", d),   int'(o_bit[d]),   m_busy[d] ? int'(m_frame[d][e_sel]) : 0);
         chk($sformatf("d%0d_first", d), int'(o_first[d]), int'(m_busy[d] && e_sel == 0));
         chk($sformatf("d%0d_last", d),  int'(o_last[d]),  int'(m_busy[d] && e_sel == 7));
         chk($sformatf("d%0d_ready", d), int'(o_ready[d]), int'(e_ready));
         if (d == 0) begin
            if (!rst_n) begin
               sent_q.delete();
               cap = 8'd0;
            end else begin
               if (o_valid[0] && out_en) begin
                  cap[o_sel[0]] = o_bit[0];
                  if (o_last[0]) begin
                     chk("recon_queue_nonempty", int'(sent_q.size() > 0), 1);
                     if (sent_q.size() > 0) chk("recon_byte", int'(cap), int'(sent_q.pop_front()));
                     frames_done++;
                  end
               end
               if (in_valid && e_ready) sent_q.push_back(in_data);
            end
         end
         if (!rst_n) begin
            m_busy[d] = 1'b0;
            m_pos[d]  = 0;
         end else begin
            acc = in_valid && e_ready;
            if (m_busy[d] && out_en) begin
               m_pos[d]++;
               if (m_pos[d] == 8*h) begin
                  m_busy[d] = 1'b0;
                  m_pos[d]  = 0;
               end
            end
            if (acc) begin
               m_busy[d]  = 1'b1;
               m_frame[d] = in_data;
               m_pos[d]   = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((o_valid != 2'b00) && n < 200) begin
         tick();
         n++;
      end
      chk("wait_idle_timeout", int'(o_valid == 2'b00), 1);
   endtask

   initial begin
      logic [7:0] pat;
      int         cnt;
      int         guard;
      m_busy  = '{1'b0, 1'b0};
      m_pos   = '{0, 0};
      m_frame = '{8'd0, 8'd0};
      cap     = 8'd0;
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_en = 1'b1;
      tick(); tick();
      chk("rst_ready", int'(o_ready[0]), 1);
      chk("rst_valid", int'(o_valid[0]), 0);
      chk("rst_sel",   int'(o_sel[0]),   0);
      rst_n = 1'b1; in_valid = 1'b0;
      tick();
      chk("no_accept_in_reset", int'(o_valid), 0);

      // single frame A5 on HOLD=1: 1,0,1,0,0,1,0,1
      pat = 8'b1010_0101;
      in_data = 8'hA5; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("a5_bit%0d", i), int'(o_bit[0]), int'(pat[i]));
         chk($sformatf("a5_sel%0d", i), int'(o_sel[0]), i);
         chk($sformatf("a5_first%0d", i), int'(o_first[0]), int'(i == 0));
         chk($sformatf("a5_last%0d", i), int'(o_last[0]), int'(i == 7));
         tick();
      end
      chk("a5_idle_after", int'(o_valid[0]), 0);
      wait_idle();

      // 0x81 on HOLD=4: 32 cycles, bit high in slots 0 and 7
      in_data = 8'h81; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cnt = 0;
      while (o_valid[1] && cnt < 40) begin
         chk("h4_sel", int'(o_sel[1]), cnt / 4);
         chk("h4_bit", int'(o_bit[1]), int'(cnt < 4 || cnt >= 28));
         cnt++;
         tick();
      end
      chk("h4_frame_len", cnt, 32);
      wait_idle();

      // back-to-back FF then 00 on HOLD=1; in_data changes mid-frame
      in_data = 8'hFF; in_valid = 1'b1;
      tick();
      in_data = 8'h00;
      for (int i = 0; i < 16; i++) begin
         chk("b2b_valid", int'(o_valid[0]), 1);
         chk("b2b_sel",   int'(o_sel[0]),   i % 8);
         chk("b2b_bit",   int'(o_bit[0]),   int'(i < 8));
         chk("b2b_ready", int'(o_ready[0]), int'(i % 8 == 7));
         if (i == 15) in_valid = 1'b0;
         tick();
      end
      chk("b2b_idle", int'(o_valid[0]), 0);
      wait_idle();

      // freeze during slot 3 for 5 cycles
      in_data = 8'h08; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      out_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("frz_sel",   int'(o_sel[0]),   3);
         chk("frz_bit",   int'(o_bit[0]),   1);
         chk("frz_ready", int'(o_ready[0]), 0);
         tick();
      end
      out_en = 1'b1;
      chk("frz_sel_6th", int'(o_sel[0]), 3);
      tick();
      chk("frz_resume_sel", int'(o_sel[0]), 4);
      chk("frz_resume_bit", int'(o_bit[0]), 0);
      wait_idle();

      // reset during slot 5 aborts the frame
      in_data = 8'h20; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("abort_pre_sel", int'(o_sel[0]), 5);
      chk("abort_pre_bit", int'(o_bit[0]), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      chk("abort_valid", int'(o_valid[0]), 0);
      chk("abort_sel",   int'(o_sel[0]),   0);
      chk("abort_ready", int'(o_ready[0]), 1);
      in_data = 8'h3C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("abort_new_valid", int'(o_valid[0]), 1);
      chk("abort_new_sel",   int'(o_sel[0]),   0);
      chk("abort_new_first", int'(o_first[0]), 1);
      chk("abort_new_bit",   int'(o_bit[0]),   0);
      wait_idle();

      // 256 random frames with random out_en gaps, reconstructed downstream
      frames_done = 0;
      guard = 0;
      while (frames_done < 256 && guard < 20000) begin
         in_valid = ($urandom_range(0, 3) != 0);
         in_data  = 8'($urandom);
         out_en   = ($urandom_range(0, 3) != 0);
         tick();
         guard++;
      end
      chk("recon_256_frames", int'(frames_done >= 256), 1);
      in_valid = 1'b0; out_en = 1'b1;
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/mux8way_tdm_tx.md
MUX8WAY_TDM_TX -- requirements
Module: mux8way_tdm_tx

Interface
REQ-001 The block SHALL have parameter HOLD, default 1, giving the clock cycles each slot is held on the line (legal 1..16).
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  in_data holds a frame to send.
REQ-005 in_data  input  8  frame; bit0 is slot a (sel 000) through bit7 is slot h (sel 111).
REQ-006 in_ready  output  1  the block accepts in_data this cycle.
REQ-007 out_en  input  1  downstream enable; 0 freezes transmission.
REQ-008 out_bit  output  1  current slot bit.
REQ-009 out_sel  output  3  current slot index, for a downstream DMux8Way.
REQ-010 out_valid  output  1  out_bit/out_sel carry frame data.
REQ-011 out_first  output  1  high for every cycle of slot 0.
REQ-012 out_last  output  1  high for every cycle of slot 7.

Function
REQ-013 The block SHALL implement two states: IDLE (no frame held) and SEND (frame being transmitted).
REQ-014 A frame SHALL be accepted on any rising edge where in_valid=1 and in_ready=1; in_data is captured into an internal 8-bit register.
REQ-015 in_ready SHALL be 1 in IDLE, and 1 in SEND only during the final cycle of slot 7 while out_en=1; it SHALL be 0 otherwise.
REQ-016 On acceptance from IDLE the block SHALL enter SEND the next cycle with out_sel=0, out_valid=1 and out_bit=in_data[0]; latency from acceptance to first slot is 1 cycle.
REQ-017 In SEND, out_bit SHALL equal captured bit [out_sel]; out_valid SHALL be 1.
REQ-018 A hold counter SHALL count 0..HOLD-1 per slot; out_sel SHALL increment only on a cycle where the hold counter equals HOLD-1 and out_en=1.
REQ-019 While out_en=0 the hold counter, out_sel, the frame register and the state SHALL remain unchanged, and outputs SHALL remain constant.
REQ-020 At the end of slot 7 (hold counter = HOLD-1, out_en=1) the block SHALL return to IDLE with out_sel=0 if no frame is accepted in that cycle.
REQ-021 If a frame is accepted in that same cycle, the block SHALL stay in SEND and present slot 0 of the new frame on the next cycle with no bubble.
REQ-022 out_sel SHALL wrap 7->0 only via REQ-020/REQ-021 and never exceed 7.
REQ-023 In IDLE, out_bit=0, out_sel=0, out_valid=0, out_first=0, out_last=0.
REQ-024 in_data changes while the block is in SEND SHALL NOT affect the frame being transmitted.
REQ-025 A complete frame SHALL occupy exactly 8*HOLD cycles with out_en held at 1.

Reset
REQ-026 While rst_n=0 at a rising edge, the block SHALL enter IDLE and clear the hold counter, out_sel and the frame register.
REQ-027 After reset: in_ready=1, out_valid=0, out_bit=0, out_sel=0, out_first=0, out_last=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame; no remaining slots are emitted, and the frame is not resent.
REQ-029 in_valid asserted in a reset cycle SHALL NOT be accepted.

Verification
REQ-030 HOLD=1, in_data=8'b1010_0101 accepted once -> slots 0..7 on consecutive cycles with out_bit 1,0,1,0,0,1,0,1, out_first on slot 0 only, out_last on slot 7 only, then IDLE.
REQ-031 HOLD=1, in_valid held high with 8'hFF then 8'h00 -> 16 contiguous valid cycles, out_sel 0..7,0..7, in_ready pulses on slot 7 only, no bubble.
REQ-032 HOLD=4, in_data=8'h81 -> each out_sel value held 4 cycles, out_bit=1 during slots 0 and 7 only, frame occupies 32 cycles.
REQ-033 HOLD=1, out_en=0 for 5 cycles during slot 3 -> out_sel stays 3 and out_bit stays constant for 6 cycles total, then resumes at slot 4; in_ready stays 0.
REQ-034 rst_n=0 for one cycle during slot 5 -> next cycle out_valid=0, out_sel=0, in_ready=1; a new frame is accepted and starts at slot 0.
REQ-035 Downstream DMux8Way plus 8 capture flops reconstruct every sent in_data byte exactly over 256 random frames with random out_en gaps.
